// File: rtl/k005297_heatseq.sv
// Purpose: bubble-memory thermal sequencer (heater, 2MHz clock gate, transfer hold); K005297_HEATSEQ_DRAIN_TIMEOUT_EN adds a drain timeout.
// Latency: TEMPLO_n is 2-flop synchronised then debounced over DEBOUNCE_TICKS ticks; outputs are registered and change with the state.
// Backpressure: o_XFER_HOLD blocks new transfers outside RUN; DRAIN keeps the clock alive until i_XFER_BUSY drops.
module k005297_heatseq #(
    parameter int unsigned DEBOUNCE_TICKS = 16,
    parameter int unsigned SETTLE_TICKS   = 1024,
    parameter int unsigned TIMEOUT_TICKS  = 1048576,
    parameter int unsigned DRAIN_TICKS    = 4096
) (
    input  logic       i_MCLK,
    input  logic       i_RST,
    input  logic       i_CLK4M_PCEN_n,
    input  logic       i_TEMPLO_n,
    input  logic       i_XFER_BUSY,
    input  logic       i_FAULT_CLR,
    output logic       o_HEATEN_n,
    output logic       o_CLK2M_STOP_n,
    output logic       o_XFER_HOLD,
    output logic       o_READY,
    output logic       o_FAULT,
    output logic       o_XFER_ABORT,
    output logic [2:0] o_STATE
);

    localparam int unsigned CNT_TOP = (TIMEOUT_TICKS > DRAIN_TICKS) ? TIMEOUT_TICKS : DRAIN_TICKS;
    localparam int CW = $clog2(CNT_TOP + 1);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEAT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_STOP   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [DW-1:0]   db_cnt;
    logic            sync1;
    logic            sync2;
    logic            filt_ok;
    logic            clr_pend;
    logic            tick;

    assign tick    = ~i_CLK4M_PCEN_n;
    assign o_STATE = state;

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= i_TEMPLO_n;
            sync2 <= sync1;
        end
    end

    // Any sample equal to the current level restarts the run of differing samples.
    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            filt_ok <= 1'b0;
            db_cnt  <= '0;
        end else if (tick) begin
            if (sync2 != filt_ok) begin
                if (db_cnt == DW'(DEBOUNCE_TICKS - 1)) begin
                    filt_ok <= sync2;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // A clear request can land between ticks; hold it until the tick that can act on it.
    always_ff @(posedge i_MCLK) begin
        if (i_RST || tick)
            clr_pend <= 1'b0;
        else if (i_FAULT_CLR)
            clr_pend <= 1'b1;
    end

`ifdef K005297_HEATSEQ_DRAIN_TIMEOUT_EN
    logic abort_nxt;
`endif

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
`ifdef K005297_HEATSEQ_DRAIN_TIMEOUT_EN
        abort_nxt = 1'b0;
`endif
        case (state)
            ST_IDLE:   nxt = ST_HEAT;
            ST_HEAT: begin
                if (filt_ok)
                    nxt = ST_SETTLE;
                else if (cnt == CW'(TIMEOUT_TICKS - 1))
                    nxt = ST_FAULT;
                else
                    cnt_nxt = cnt + CW'(1);
            end
            ST_SETTLE: begin
                if (!filt_ok)
                    nxt = ST_HEAT;
                else if (cnt == CW'(SETTLE_TICKS - 1))
                    nxt = ST_RUN;
                else
                    cnt_nxt = cnt + CW'(1);
            end
            ST_RUN: begin
                if (!filt_ok)
                    nxt = i_XFER_BUSY ? ST_DRAIN : ST_STOP;
            end
            ST_DRAIN: begin
                if (!i_XFER_BUSY)
                    nxt = ST_STOP;
`ifdef K005297_HEATSEQ_DRAIN_TIMEOUT_EN
                else if (cnt == CW'(DRAIN_TICKS - 1)) begin
                    nxt       = ST_STOP;
                    abort_nxt = 1'b1;
                end else
                    cnt_nxt = cnt + CW'(1);
`endif
            end
            ST_STOP:   nxt = ST_HEAT;
            ST_FAULT: begin
                if (clr_pend || i_FAULT_CLR)
                    nxt = ST_IDLE;
            end
            default:   nxt = ST_IDLE;
        endcase
        // Each timed state measures from its own entry.
        if (nxt != state)
            cnt_nxt = '0;
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            o_HEATEN_n     <= 1'b1;
            o_CLK2M_STOP_n <= 1'b0;
            o_XFER_HOLD    <= 1'b1;
            o_READY        <= 1'b0;
            o_FAULT        <= 1'b0;
        end else if (tick) begin
            state          <= nxt;
            cnt            <= cnt_nxt;
            o_HEATEN_n     <= !(nxt inside {ST_HEAT, ST_SETTLE, ST_DRAIN, ST_STOP});
            o_CLK2M_STOP_n <= (nxt == ST_RUN) || (nxt == ST_DRAIN);
            o_XFER_HOLD    <= (nxt != ST_RUN);
            o_READY        <= (nxt == ST_RUN);
            o_FAULT        <= (nxt == ST_FAULT);
        end
    end

`ifdef K005297_HEATSEQ_DRAIN_TIMEOUT_EN
    always_ff @(posedge i_MCLK) begin
        if (i_RST)
            o_XFER_ABORT <= 1'b0;
        else if (tick)
            o_XFER_ABORT <= abort_nxt;
    end
`else
    assign o_XFER_ABORT = 1'b0;
`endif

endmodule

// File: tb/tb_k005297_heatseq.sv
// Directed bench for k005297_heatseq with a tick-level behavioural model and literal checkpoints.
`timescale 1ns/1ps
module tb_k005297_heatseq;
    localparam int DEB = 4;
    localparam int SET = 8;
    localparam int TMO = 64;
    localparam int DRN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pcen_n = 1'b1;
    logic       templo_n = 1'b1;
    logic       busy = 1'b0;
    logic       fclr = 1'b0;
    logic       heaten_n, stop_n, hold, ready, fault, abort;
    logic [2:0] state;

    k005297_heatseq #(
        .DEBOUNCE_TICKS(DEB),
        .SETTLE_TICKS  (SET),
        .TIMEOUT_TICKS (TMO),
        .DRAIN_TICKS   (DRN)
    ) dut (
        .i_MCLK        (clk),
        .i_RST         (rst),
        .i_CLK4M_PCEN_n(pcen_n),
        .i_TEMPLO_n    (templo_n),
        .i_XFER_BUSY   (busy),
        .i_FAULT_CLR   (fclr),
        .o_HEATEN_n    (heaten_n),
        .o_CLK2M_STOP_n(stop_n),
        .o_XFER_HOLD   (hold),
        .o_READY       (ready),
        .o_FAULT       (fault),
        .o_XFER_ABORT  (abort),
        .o_STATE       (state)
    );

    always #5 clk = ~clk;

    int cmp_n = 0;
    int bad_n = 0;
    int tick_no = 0;
    bit chk_en = 0;
    bit saw_ready = 0;
    bit saw_abort = 0;

    int m_state, m_tin, m_run;
    bit m_s1, m_s2, m_filt, m_clr, m_abort;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outputs per state: heaten_n, clk2m_stop_n, hold, ready, fault.
    function automatic logic [8:0] exp_vec(input int s, input bit ab);
        logic [4:0] o;
        case (s)
            0:       o = 5'b10100;
            1:       o = 5'b00100;
            2:       o = 5'b00100;
            3:       o = 5'b11010;
            4:       o = 5'b01100;
            5:       o = 5'b00100;
            6:       o = 5'b10101;
            default: o = 5'b00000;
        endcase
        return {3'(s), o, ab};
    endfunction

    // Model: m_tin counts ticks spent in the current state, m_run counts differing filter samples.
    always @(posedge clk) begin : model
        int ns;
        bit ab;
        if (rst) begin
            m_state = 0; m_tin = 0; m_run = 0;
            m_s1 = 0; m_s2 = 0; m_filt = 0; m_clr = 0; m_abort = 0;
        end else begin
            if (!pcen_n) begin
                tick_no++;
                ns = m_state;
                ab = 0;
                m_tin++;
                case (m_state)
                    0: ns = 1;
                    1: if (m_filt) ns = 2; else if (m_tin >= TMO) ns = 6;
                    2: if (!m_filt) ns = 1; else if (m_tin >= SET) ns = 3;
                    3: if (!m_filt) ns = busy ? 4 : 5;
                    4: begin
                        if (!busy) ns = 5;
`ifdef K005297_HEATSEQ_DRAIN_TIMEOUT_EN
                        else if (m_tin >= DRN) begin ns = 5; ab = 1; end
`endif
                    end
                    5: ns = 1;
                    6: if (m_clr || fclr) ns = 0;
                    default: ns = 0;
                endcase
                if (ns != m_state) m_tin = 0;
                m_state = ns;
                m_abort = ab;
                m_clr = 0;
                if (m_s2 != m_filt) begin
                    m_run++;
                    if (m_run == DEB) begin m_filt = m_s2; m_run = 0; end
                end else begin
                    m_run = 0;
                end
            end else if (fclr) begin
                m_clr = 1;
            end
            m_s2 = m_s1;
            m_s1 = templo_n;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_outputs", {state, heaten_n, stop_n, hold, ready, fault, abort}, exp_vec(m_state, m_abort));
            if (ready === 1'b1) saw_ready = 1;
            if (abort === 1'b1) saw_abort = 1;
        end
    end

    task automatic mclk();
        @(negedge clk);
        pcen_n = ~pcen_n;
    endtask

    // Let n ticks pass, then stop at a negedge whose following posedge is a tick.
    task automatic to_tick(input int n);
        int t;
        t = tick_no + n;
        while (tick_no < t) mclk();
        while (pcen_n !== 1'b0) mclk();
    endtask

    task automatic wait_state(input string name, input logic [2:0] tgt, output int ticks);
        int t0, k;
        t0 = tick_no;
        k = 0;
        do begin
            mclk();
            k++;
        end while (state !== tgt && k < 400);
        ticks = tick_no - t0;
        check(name, state, tgt);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (4) mclk();
        chk_en = 1;
        check("rst_state", state, 0);
        check("rst_outs", {heaten_n, stop_n, hold, ready, fault, abort}, 6'b101000);
        rst = 1'b0;

        // Power-up warm-up with temperature already OK.
        wait_state("s1_heat", 3'd1, n);   check("s1_idle_ticks", n, 1);
        check("s1_heat_outs", {heaten_n, stop_n, hold}, 3'b001);
        wait_state("s1_settle", 3'd2, n); check("s1_heat_ticks", n, 5);
        wait_state("s1_run", 3'd3, n);    check("s1_settle_ticks", n, 8);
        check("s1_run_outs", {heaten_n, stop_n, hold, ready}, 4'b1101);

        // Three-tick glitch must be filtered out.
        to_tick(0);
        templo_n = 1'b0;
        repeat (6) mclk();
        templo_n = 1'b1;
        to_tick(12);
        check("s3_state", state, 3);
        check("s3_ready", ready, 1);

        // Temperature drop during a transfer: drain, stop, reheat.
        busy = 1'b1;
        to_tick(0);
        templo_n = 1'b0;
        wait_state("s2_drain", 3'd4, n); check("s2_drain_ticks", n, 6);
        check("s2_drain_outs", {heaten_n, stop_n, hold, ready}, 4'b0110);
        busy = 1'b0;
        wait_state("s2_stop", 3'd5, n);  check("s2_stop_ticks", n, 1);
        wait_state("s2_heat", 3'd1, n);  check("s2_stop_len", n, 1);

        // Heater never reaches temperature.
        wait_state("s4_fault", 3'd6, n); check("s4_timeout_ticks", n, 64);
        check("s4_fault_outs", {heaten_n, fault}, 2'b11);
        fclr = 1'b1;
        mclk();
        fclr = 1'b0;
        wait_state("s4_idle", 3'd0, n);  check("s4_clr_ticks", n, 1);
        wait_state("s4_heat", 3'd1, n);  check("s4_reheat_ticks", n, 1);

        // Filtered OK lands on the timeout tick: OK wins.
        to_tick(58);
        templo_n = 1'b1;
        wait_state("s7_settle", 3'd2, n); check("s7_ok_vs_timeout", n, 6);

        // Filtered LOW lands on the settle completion tick: back to HEAT.
        to_tick(2);
        templo_n = 1'b0;
        saw_ready = 0;
        wait_state("s5_heat", 3'd1, n);  check("s5_low_vs_settle", n, 6);
        check("s5_no_ready", saw_ready, 0);

        templo_n = 1'b1;
        wait_state("rec_settle", 3'd2, n);
        wait_state("rec_run", 3'd3, n);  check("rec_settle_ticks", n, 8);

        // Drain with a transfer that never finishes.
        busy = 1'b1;
        to_tick(0);
        templo_n = 1'b0;
        wait_state("s6_drain", 3'd4, n); check("s6_drain_ticks", n, 6);
`ifdef K005297_HEATSEQ_DRAIN_TIMEOUT_EN
        wait_state("s6_stop", 3'd5, n);  check("s6_abort_tick", n, 16);
        check("s6_abort_pulse", abort, 1);
        mclk();
        mclk();
        check("s6_abort_clear", abort, 0);
        check("s6_heat", state, 1);
        busy = 1'b0;
`else
        templo_n = 1'b1;
        saw_abort = 0;
        to_tick(40);
        check("s6_still_drain", state, 4);
        check("s6_no_abort", saw_abort, 0);
        busy = 1'b0;
        wait_state("s6_stop", 3'd5, n);  check("s6_release_ticks", n, 1);
`endif

        // Reset in the middle of operation, coincident with a tick.
        to_tick(3);
        rst = 1'b1;
        mclk();
        check("mid_rst_state", state, 0);
        check("mid_rst_outs", {heaten_n, stop_n, hold, ready, fault, abort}, 6'b101000);
        rst = 1'b0;
        repeat (4) mclk();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end
endmodule
